irq_enable_pending_unit: RTL and testbench

//  Parametrised successor of the MIE register: holds mie and mip for MSI/MTI/MEI plus NUM_LOCAL platform interrupts (bits 16+).

---
 rtl/irq_enable_pending_unit_pkg.sv | 30 +++
 rtl/irq_enable_pending_unit_if.sv | 24 ++
 rtl/irq_enable_pending_unit_prio_enc.sv | 22 ++
 rtl/irq_enable_pending_unit.sv | 152 +++++++++++++++
 tb/tb_irq_enable_pending_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_enable_pending_unit_pkg.sv
// Shared constants for the machine interrupt enable/pending unit: CSR addresses, op codes,
// cause codes and the local-line mask helper.
package csr_irq_pkg;

    localparam logic [11:0] CSR_MIE = 12'h304;
    localparam logic [11:0] CSR_MIP = 12'h344;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [4:0] CAUSE_MSI   = 5'd3;
    localparam logic [4:0] CAUSE_MTI   = 5'd7;
    localparam logic [4:0] CAUSE_MEI   = 5'd11;
    localparam logic [4:0] CAUSE_LOCAL = 5'd16;

    // One bit per implemented local line, aligned to mie/mip bit 16.
    function automatic logic [15:0] local_mask(input int unsigned num_local);
        logic [15:0] m;
        m = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < num_local) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_enable_pending_unit_if.sv
// CSR access port and trap-controller handshake of the interrupt enable/pending unit.
interface irq_enable_pending_unit_if;
    import csr_irq_pkg::*;

    logic [11:0] csr_addr_in;
    logic        csr_wr_en_in;
    csr_op_e     csr_op_in;
    logic [31:0] csr_wdata_in;
    logic [31:0] csr_rdata_out;
    logic        irq_ack_in;
    logic        irq_valid_out;
    logic [4:0]  irq_cause_out;

    modport master (
        output csr_addr_in, csr_wr_en_in, csr_op_in, csr_wdata_in, irq_ack_in,
        input  csr_rdata_out, irq_valid_out, irq_cause_out
    );

    modport slave (
        input  csr_addr_in, csr_wr_en_in, csr_op_in, csr_wdata_in, irq_ack_in,
        output csr_rdata_out, irq_valid_out, irq_cause_out
    );

endinterface

// File: rtl/irq_enable_pending_unit_prio_enc.sv
// Combinational interrupt priority encoder: highest local line first, then MEI, MSI, MTI.
module irq_prio_enc
    import csr_irq_pkg::*;
(
    input  logic [31:0] pend_i,
    output logic        any_o,
    output logic [4:0]  cause_o
);

    // Later assignments override earlier ones, so the lowest priority is written first.
    always_comb begin
        any_o   = |pend_i;
        cause_o = '0;
        if (pend_i[CAUSE_MTI]) cause_o = CAUSE_MTI;
        if (pend_i[CAUSE_MSI]) cause_o = CAUSE_MSI;
        if (pend_i[CAUSE_MEI]) cause_o = CAUSE_MEI;
        for (int unsigned i = 16; i < 32; i++) begin
            if (pend_i[i]) cause_o = 5'(i);
        end
    end

endmodule

// File: rtl/irq_enable_pending_unit.sv
// mie/mip register pair with edge/level local interrupts and a registered request to the trap unit.
// Optional IRQ_INPUT_SYNC_EN inserts a 2-flop synchronizer on all interrupt inputs.
module irq_enable_pending_unit
    import csr_irq_pkg::*;
#(
    parameter int unsigned NUM_LOCAL = 16,
    parameter logic [15:0] EDGE_MASK = 16'h0000
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    irq_enable_pending_unit_if.slave bus,
    input  logic                     msip_in,
    input  logic                     mtip_in,
    input  logic                     meip_in,
    input  logic [NUM_LOCAL-1:0]     lirq_in,
    input  logic                     mstatus_mie_in,
    output logic [31:0]              mie_reg_out,
    output logic [31:0]              mip_reg_out
);

    localparam logic [15:0] LOCAL_MASK  = local_mask(NUM_LOCAL);
    localparam logic [15:0] EDGE_LINES  = EDGE_MASK & LOCAL_MASK;
    localparam logic [15:0] LEVEL_LINES = ~EDGE_MASK & LOCAL_MASK;
    localparam logic [31:0] MIE_WMASK   = {LOCAL_MASK, 16'h0888};

    logic [15:0] lirq_raw;
    logic [18:0] in_raw, in_s;
    logic [15:0] lirq_s;
    logic        msip_s, mtip_s, meip_s;

    logic [31:0] mie_q, mie_d;
    logic [15:0] epend_q, epend_d;
    logic [15:0] prev_q, prev_d;
    logic        valid_q, valid_d;
    logic [4:0]  cause_q, cause_d;

    logic [15:0] rise, clr;
    logic [31:0] mip_img, mip_arb, pend;
    logic        enc_any;
    logic [4:0]  enc_cause;

    if (NUM_LOCAL > 0) begin : g_local
        assign lirq_raw = 16'(lirq_in);
    end else begin : g_no_local
        assign lirq_raw = '0;
    end

    assign in_raw = {meip_in, mtip_in, msip_in, lirq_raw};

`ifdef IRQ_INPUT_SYNC_EN
    logic [18:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = in_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = in_raw;
`endif

    assign lirq_s = in_s[15:0] & LOCAL_MASK;
    assign msip_s = in_s[16];
    assign mtip_s = in_s[17];
    assign meip_s = in_s[18];

    always_comb begin
        rise   = lirq_s & ~prev_q & EDGE_LINES;
        prev_d = lirq_s & EDGE_LINES;

        clr = '0;
        if (bus.csr_wr_en_in && bus.csr_addr_in == CSR_MIP) begin
            if (bus.csr_op_in == CSR_OP_WRITE) clr = ~bus.csr_wdata_in[31:16];
            if (bus.csr_op_in == CSR_OP_CLEAR) clr = bus.csr_wdata_in[31:16];
        end
        if (bus.irq_ack_in && cause_q >= CAUSE_LOCAL) clr[cause_q[3:0]] = 1'b1;

        // A new edge beats a same-cycle clear or ack so no request is lost.
        epend_d = ((epend_q & ~clr) | rise) & EDGE_LINES;
    end

    always_comb begin
        mie_d = mie_q;
        if (bus.csr_wr_en_in && bus.csr_addr_in == CSR_MIE) begin
            case (bus.csr_op_in)
                CSR_OP_WRITE: mie_d = bus.csr_wdata_in;
                CSR_OP_SET:   mie_d = mie_q | bus.csr_wdata_in;
                CSR_OP_CLEAR: mie_d = mie_q & ~bus.csr_wdata_in;
                default:      mie_d = mie_q;
            endcase
        end
        mie_d = mie_d & MIE_WMASK;
    end

    // Visible image uses latched edges; arbitration sees the next-state edges so a fresh edge
    // requests within one cycle and an acked edge stops requesting immediately.
    assign mip_img = {epend_q | (lirq_s & LEVEL_LINES), 4'b0, meip_s, 3'b0, mtip_s, 3'b0,
                      msip_s, 3'b0};
    assign mip_arb = {epend_d | (lirq_s & LEVEL_LINES), 4'b0, meip_s, 3'b0, mtip_s, 3'b0,
                      msip_s, 3'b0};
    assign pend    = mie_q & mip_arb;

    irq_prio_enc u_prio_enc (
        .pend_i  (pend),
        .any_o   (enc_any),
        .cause_o (enc_cause)
    );

    always_comb begin
        valid_d = mstatus_mie_in & enc_any;
        cause_d = enc_any ? enc_cause : cause_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mie_q   <= '0;
            epend_q <= '0;
            prev_q  <= '0;
            valid_q <= 1'b0;
            cause_q <= '0;
        end else begin
            mie_q   <= mie_d;
            epend_q <= epend_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        bus.csr_rdata_out = '0;
        if (bus.csr_addr_in == CSR_MIE) bus.csr_rdata_out = mie_q;
        if (bus.csr_addr_in == CSR_MIP) bus.csr_rdata_out = mip_img;
    end

    assign bus.irq_valid_out = valid_q;
    assign bus.irq_cause_out = cause_q;
    assign mie_reg_out       = mie_q;
    assign mip_reg_out       = mip_img;

endmodule

// File: tb/tb_irq_enable_pending_unit.sv
// Directed plus random bench for irq_enable_pending_unit against a rule-level reference model.
module tb_irq_enable_pending_unit;
    import csr_irq_pkg::*;

    localparam int unsigned NL      = 16;
    localparam logic [15:0] TB_EDGE = 16'h00F1;
`ifdef IRQ_INPUT_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = SYNC ? 3 : 1;
    localparam int SD  = SYNC ? 2 : 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        msip = 1'b0, mtip = 1'b0, meip = 1'b0;
    logic [15:0] lirq = '0;
    logic        mstatus = 1'b0;
    logic [31:0] mie_out, mip_out;

    irq_enable_pending_unit_if bus ();

    irq_enable_pending_unit #(
        .NUM_LOCAL (NL),
        .EDGE_MASK (TB_EDGE)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .bus            (bus),
        .msip_in        (msip),
        .mtip_in        (mtip),
        .meip_in        (meip),
        .lirq_in        (lirq),
        .mstatus_mie_in (mstatus),
        .mie_reg_out    (mie_out),
        .mip_reg_out    (mip_out)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_mie;
    logic [15:0] m_ep, m_prev;
    logic        m_valid;
    logic [4:0]  m_cause;
    logic [18:0] m_d1, m_d2, m_eff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mip_of(input logic [15:0] ep, input logic [18:0] e);
        return {ep | (e[15:0] & ~TB_EDGE), 4'b0, e[18], 3'b0, e[17], 3'b0, e[16], 3'b0};
    endfunction

    // Priority order read straight off the rules: local 31..16, then 11, 3, 7.
    task automatic pick(input logic [31:0] p, output logic found, output logic [4:0] c);
        found = 1'b0;
        c     = '0;
        for (int i = 31; i >= 16; i--) begin
            if (!found && p[i]) begin
                found = 1'b1;
                c     = 5'(i);
            end
        end
        if (!found && p[11]) begin found = 1'b1; c = 5'd11; end
        if (!found && p[3])  begin found = 1'b1; c = 5'd3;  end
        if (!found && p[7])  begin found = 1'b1; c = 5'd7;  end
    endtask

    // One clock: advance the model on the edge, then compare every output.
    task automatic cyc();
        logic [18:0] x, e;
        logic [15:0] rise, clr, ep_n;
        logic [31:0] p, rd;
        logic        found;
        logic [4:0]  c;
        @(posedge clk);
        x = {meip, mtip, msip, lirq};
        if (!rst) begin
            m_mie = '0; m_ep = '0; m_prev = '0; m_valid = 1'b0; m_cause = '0;
            m_d1 = '0; m_d2 = '0;
        end else begin
            e    = SYNC ? m_d2 : x;
            rise = TB_EDGE & e[15:0] & ~m_prev;
            clr  = '0;
            if (bus.csr_wr_en_in && bus.csr_addr_in == CSR_MIP) begin
                if (bus.csr_op_in == CSR_OP_WRITE) clr = ~bus.csr_wdata_in[31:16];
                if (bus.csr_op_in == CSR_OP_CLEAR) clr = bus.csr_wdata_in[31:16];
            end
            if (bus.irq_ack_in && m_cause >= 5'd16) clr[int'(m_cause) - 16] = 1'b1;
            ep_n = ((m_ep & ~clr) | rise) & TB_EDGE;
            p    = m_mie & mip_of(ep_n, e);
            pick(p, found, c);
            m_valid = mstatus && found;
            if (found) m_cause = c;
            if (bus.csr_wr_en_in && bus.csr_addr_in == CSR_MIE) begin
                if (bus.csr_op_in == CSR_OP_WRITE) m_mie = bus.csr_wdata_in;
                if (bus.csr_op_in == CSR_OP_SET)   m_mie = m_mie | bus.csr_wdata_in;
                if (bus.csr_op_in == CSR_OP_CLEAR) m_mie = m_mie & ~bus.csr_wdata_in;
                m_mie = m_mie & 32'hFFFF_0888;
            end
            m_ep   = ep_n;
            m_prev = e[15:0];
            m_d2   = m_d1;
            m_d1   = x;
        end
        m_eff = SYNC ? m_d2 : x;
        #1;
        rd = '0;
        if (bus.csr_addr_in == CSR_MIE) rd = m_mie;
        if (bus.csr_addr_in == CSR_MIP) rd = mip_of(m_ep, m_eff);
        chk("mdl_mie", mie_out, m_mie);
        chk("mdl_mip", mip_out, mip_of(m_ep, m_eff));
        chk("mdl_valid", 32'(bus.irq_valid_out), 32'(m_valid));
        chk("mdl_cause", 32'(bus.irq_cause_out), 32'(m_cause));
        chk("mdl_rdata", bus.csr_rdata_out, rd);
    endtask

    task automatic csr(input logic [11:0] a, input csr_op_e op, input logic [31:0] d);
        bus.csr_addr_in  = a;
        bus.csr_op_in    = op;
        bus.csr_wdata_in = d;
        bus.csr_wr_en_in = 1'b1;
        cyc();
        bus.csr_wr_en_in = 1'b0;
        bus.csr_op_in    = CSR_OP_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.csr_addr_in  = 12'h300;
        bus.csr_wr_en_in = 1'b0;
        bus.csr_op_in    = CSR_OP_NONE;
        bus.csr_wdata_in = '0;
        bus.irq_ack_in   = 1'b0;

        // Reset with all local lines high
        rst  = 1'b0;
        lirq = 16'hFFFF;
        repeat (2) cyc();
        chk("rst_mie", mie_out, 32'h0);
        chk("rst_valid", 32'(bus.irq_valid_out), 32'h0);
        chk("rst_cause", 32'(bus.irq_cause_out), 32'h0);
        chk("rst_mip_edge", mip_out & {TB_EDGE, 16'h0}, 32'h0);
        rst = 1'b1;
        cyc();
        lirq = '0;
        cyc();

        // mie write/set/clear and unwritable bits
        csr(CSR_MIE, CSR_OP_WRITE, 32'h0001_0888);
        csr(CSR_MIE, CSR_OP_SET, 32'h0002_0000);
        csr(CSR_MIE, CSR_OP_CLEAR, 32'h0000_0080);
        chk("mie_ops", mie_out, 32'h0003_0808);
        bus.csr_addr_in = CSR_MIE;
        chk("mie_rdata", bus.csr_rdata_out, 32'h0003_0808);
        csr(CSR_MIE, CSR_OP_WRITE, 32'hFFFF_FFFF);
        chk("mie_wmask", mie_out, 32'hFFFF_0888);

        // Edge line 0: pulse, hold, ack
        csr(CSR_MIP, CSR_OP_WRITE, 32'h0);
        mstatus = 1'b1;
        csr(CSR_MIE, CSR_OP_WRITE, 32'h0001_0000);
        repeat (3) cyc();
        lirq[0] = 1'b1;
        cyc();
        lirq[0] = 1'b0;
        repeat (LAT - 1) cyc();
        chk("edge_mip", mip_out & 32'h0001_0000, 32'h0001_0000);
        chk("edge_valid", 32'(bus.irq_valid_out), 32'h1);
        chk("edge_cause", 32'(bus.irq_cause_out), 32'd16);
        cyc();
        chk("edge_held", mip_out & 32'h0001_0000, 32'h0001_0000);
        bus.irq_ack_in = 1'b1;
        cyc();
        bus.irq_ack_in = 1'b0;
        chk("ack_clear", mip_out & 32'h0001_0000, 32'h0);
        chk("ack_valid", 32'(bus.irq_valid_out), 32'h0);

        // Priority walk
        csr(CSR_MIE, CSR_OP_WRITE, 32'h0007_0888);
        meip = 1'b1; msip = 1'b1; lirq = 16'h0004;
        repeat (LAT) cyc();
        chk("prio_local2", 32'(bus.irq_cause_out), 32'd18);
        lirq = '0;
        repeat (LAT) cyc();
        chk("prio_mei", 32'(bus.irq_cause_out), 32'd11);
        meip = 1'b0;
        repeat (LAT) cyc();
        chk("prio_msi", 32'(bus.irq_cause_out), 32'd3);
        chk("prio_valid", 32'(bus.irq_valid_out), 32'h1);

        // Edge coinciding with mip clear; then plain clear and ignored set
        msip = 1'b0;
        csr(CSR_MIE, CSR_OP_WRITE, 32'h0001_0000);
        repeat (3) cyc();
        lirq[0] = 1'b1;
        repeat (SD) cyc();
        csr(CSR_MIP, CSR_OP_CLEAR, 32'h0001_0000);
        chk("edge_beats_clr", mip_out & 32'h0001_0000, 32'h0001_0000);
        csr(CSR_MIP, CSR_OP_CLEAR, 32'h0001_0000);
        chk("mip_clr", mip_out & 32'h0001_0000, 32'h0);
        csr(CSR_MIP, CSR_OP_SET, 32'h0001_0000);
        chk("mip_set_ignored", mip_out & 32'h0001_0000, 32'h0);

        // Global enable gating
        lirq = '0;
        csr(CSR_MIE, CSR_OP_WRITE, 32'h0000_0800);
        mstatus = 1'b0;
        meip    = 1'b1;
        repeat (LAT + 1) cyc();
        chk("gmie_off", 32'(bus.irq_valid_out), 32'h0);
        mstatus = 1'b1;
        cyc();
        chk("gmie_on", 32'(bus.irq_valid_out), 32'h1);
        chk("gmie_cause", 32'(bus.irq_cause_out), 32'd11);

        // Random traffic, including occasional mid-run resets
        for (int k = 0; k < 400; k++) begin
            rst     = ($urandom_range(0, 99) != 0);
            mstatus = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) msip = 1'($urandom);
            if ($urandom_range(0, 3) == 0) mtip = 1'($urandom);
            if ($urandom_range(0, 3) == 0) meip = 1'($urandom);
            lirq             = 16'($urandom) & 16'($urandom);
            bus.irq_ack_in   = ($urandom_range(0, 2) == 0);
            bus.csr_wr_en_in = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0:       bus.csr_addr_in = CSR_MIE;
                1:       bus.csr_addr_in = CSR_MIP;
                default: bus.csr_addr_in = 12'h300;
            endcase
            bus.csr_op_in    = csr_op_e'($urandom_range(0, 3));
            bus.csr_wdata_in = $urandom;
            cyc();
        end
        rst              = 1'b1;
        bus.csr_wr_en_in = 1'b0;
        bus.irq_ack_in   = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
